// File: rtl/gpu_host_pkg.sv
// Shared definitions for gpu_host_sequencer: command op encoding, FSM states,
// run status word layout, timeout limit and the reserved-op answer.
package gpu_host_pkg;

    typedef enum logic [2:0] {
        OP_WRITE_INST = 3'd0,
        OP_WRITE_DATA = 3'd1,
        OP_READ_INST  = 3'd2,
        OP_READ_DATA  = 3'd3,
        OP_RUN        = 3'd4
    } cmd_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ_ADDR,
        ST_READ_WAIT,
        ST_RESP,
        ST_RUNNING
    } state_t;

    localparam int STATUS_HALTED_BIT    = 0;
    localparam int STATUS_EXCEPTION_BIT = 1;
    localparam int STATUS_ABORTED_BIT   = 2;
    localparam int STATUS_TIMEOUT_BIT   = 3;
    localparam int STATUS_COUNT_LSB     = 4;

    localparam logic [31:0] TIMEOUT_CYCLES  = 32'd1 << 20;
    localparam logic [31:0] RESERVED_OP_RSP = 32'hdeadbeef;

    // Count field is only 28 bits wide, so larger counts saturate to all ones.
    function automatic logic [31:0] pack_status(
        input logic        halted,
        input logic        exception,
        input logic        aborted,
        input logic        timeout,
        input logic [31:0] count
    );
        logic [31:0] s;
        s = '0;
        s[STATUS_HALTED_BIT]    = halted;
        s[STATUS_EXCEPTION_BIT] = exception;
        s[STATUS_ABORTED_BIT]   = aborted;
        s[STATUS_TIMEOUT_BIT]   = timeout;
        s[31:STATUS_COUNT_LSB]  = (|count[31:28]) ? 28'hfff_ffff : count[27:0];
        return s;
    endfunction

endpackage

// File: rtl/gpu_host_sequencer.sv
// Host-side sequencer: loads/reads GPU instruction and data RAMs and runs the GPU.
// Optional: define GPU_HOST_TIMEOUT_EN to end runs after TIMEOUT_CYCLES cycles.
module gpu_host_sequencer
    import gpu_host_pkg::*;
#(
    parameter int WORD_WIDTH      = 32,
    parameter int ADDRESS_WIDTH   = 16,
    parameter int RUN_MASK_CYCLES = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [WORD_WIDTH-1:0]    cmd_data,
    input  logic                     abort,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WORD_WIDTH-1:0]    rsp_data,
    output logic                     gpu_run,
    input  logic                     gpu_halted,
    input  logic                     gpu_exception,
    output logic                     gpu_inst_we,
    output logic                     gpu_data_we,
    output logic [ADDRESS_WIDTH-1:0] gpu_inst_addr,
    output logic [ADDRESS_WIDTH-1:0] gpu_data_addr,
    output logic [WORD_WIDTH-1:0]    gpu_inst_wdata,
    output logic [WORD_WIDTH-1:0]    gpu_data_wdata,
    input  logic [WORD_WIDTH-1:0]    gpu_inst_rdata,
    input  logic [WORD_WIDTH-1:0]    gpu_data_rdata
);

    state_t      state;
    logic        read_data_sel;
    logic [31:0] cycle_count;

    logic [31:0] count_inc;
    logic        unmasked;
    logic        halt_hit;
    logic        exc_hit;
    logic        timeout_hit;
    logic        run_exit;
    logic [31:0] status_word;

    // count_inc is the number of RUNNING cycles completed at the current edge.
    assign count_inc = (cycle_count == 32'hffff_ffff) ? cycle_count : cycle_count + 32'd1;
    assign unmasked  = (cycle_count >= 32'(RUN_MASK_CYCLES));
    assign halt_hit  = unmasked & gpu_halted;
    assign exc_hit   = unmasked & gpu_exception;
`ifdef GPU_HOST_TIMEOUT_EN
    assign timeout_hit = (count_inc == TIMEOUT_CYCLES);
`else
    assign timeout_hit = 1'b0;
`endif
    assign run_exit    = abort | halt_hit | exc_hit | timeout_hit;
    assign status_word = pack_status(halt_hit, exc_hit, abort, timeout_hit, count_inc);

    // NOTE: every register here uses <= so all next-state values come from the
    // pre-edge state; a blocking = would let later lines see half-updated values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            gpu_run        <= 1'b0;
            gpu_inst_we    <= 1'b0;
            gpu_data_we    <= 1'b0;
            gpu_inst_addr  <= '0;
            gpu_data_addr  <= '0;
            gpu_inst_wdata <= '0;
            gpu_data_wdata <= '0;
            read_data_sel  <= 1'b0;
            cycle_count    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        case (cmd_op)
                            OP_WRITE_INST: begin
                                state          <= ST_WRITE;
                                gpu_inst_we    <= 1'b1;
                                gpu_inst_addr  <= cmd_addr;
                                gpu_inst_wdata <= cmd_data;
                            end
                            OP_WRITE_DATA: begin
                                state          <= ST_WRITE;
                                gpu_data_we    <= 1'b1;
                                gpu_data_addr  <= cmd_addr;
                                gpu_data_wdata <= cmd_data;
                            end
                            OP_READ_INST: begin
                                state         <= ST_READ_ADDR;
                                gpu_inst_addr <= cmd_addr;
                                read_data_sel <= 1'b0;
                            end
                            OP_READ_DATA: begin
                                state         <= ST_READ_ADDR;
                                gpu_data_addr <= cmd_addr;
                                read_data_sel <= 1'b1;
                            end
                            OP_RUN: begin
                                state       <= ST_RUNNING;
                                gpu_run     <= 1'b1;
                                cycle_count <= '0;
                            end
                            default: begin
                                state     <= ST_RESP;
                                rsp_valid <= 1'b1;
                                rsp_data  <= WORD_WIDTH'(RESERVED_OP_RSP);
                            end
                        endcase
                    end else begin
                        // Registered so it stays low for the first edge after reset.
                        cmd_ready <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    state          <= ST_IDLE;
                    cmd_ready      <= 1'b1;
                    gpu_inst_we    <= 1'b0;
                    gpu_data_we    <= 1'b0;
                    gpu_inst_addr  <= '0;
                    gpu_data_addr  <= '0;
                    gpu_inst_wdata <= '0;
                    gpu_data_wdata <= '0;
                end
                ST_READ_ADDR: begin
                    state <= ST_READ_WAIT;
                end
                ST_READ_WAIT: begin
                    state         <= ST_RESP;
                    rsp_valid     <= 1'b1;
                    rsp_data      <= read_data_sel ? gpu_data_rdata : gpu_inst_rdata;
                    gpu_inst_addr <= '0;
                    gpu_data_addr <= '0;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_data  <= '0;
                    end
                end
                ST_RUNNING: begin
                    cycle_count <= count_inc;
                    if (run_exit) begin
                        state     <= ST_RESP;
                        gpu_run   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= WORD_WIDTH'(status_word);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                    gpu_run   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/gpu_host_sequencer.md
GPU_HOST_SEQUENCER -- requirements
Module: gpu_host_sequencer

Interface
REQ-001 Parameter WORD_WIDTH, default 32, data word width of the GPU external ports.
REQ-002 Parameter ADDRESS_WIDTH, default 16, byte-address width of the GPU external ports.
REQ-003 Parameter RUN_MASK_CYCLES, default 2, number of RUNNING cycles during which halted/exception are ignored.
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid/cmd_ready  input/output  1/1  command handshake; transfer when both are high.
REQ-007 cmd_op  input  3  0=WRITE_INST, 1=WRITE_DATA, 2=READ_INST, 3=READ_DATA, 4=RUN; 5-7 reserved.
REQ-008 cmd_addr/cmd_data  input  ADDRESS_WIDTH/WORD_WIDTH  byte address and write data.
REQ-009 abort  input  1  level; terminates a run in progress.
REQ-010 rsp_valid/rsp_ready  output/input  1/1  response handshake; transfer when both are high.
REQ-011 rsp_data  output  WORD_WIDTH  read data or run status word.
REQ-012 gpu_run  output  1  drives the GPU run input.
REQ-013 gpu_halted, gpu_exception  input  1 each  GPU status.
REQ-014 gpu_inst_we, gpu_data_we  output  1 each  GPU external RAM write enables.
REQ-015 gpu_inst_addr, gpu_data_addr  output  ADDRESS_WIDTH  GPU external RAM byte addresses.
REQ-016 gpu_inst_wdata, gpu_data_wdata  output  WORD_WIDTH  GPU external RAM write data.
REQ-017 gpu_inst_rdata, gpu_data_rdata  input  WORD_WIDTH  GPU external RAM read data, valid one cycle after address.

Function
REQ-018 States SHALL be IDLE, WRITE, READ_ADDR, READ_WAIT, RESP, RUNNING.
REQ-019 cmd_ready SHALL be high only in IDLE with rsp_valid low.
REQ-020 Accepted WRITE_*: next cycle in WRITE, exactly one we pulse with registered addr/data, then IDLE; no response.
REQ-021 Accepted READ_*: READ_ADDR drives addr, READ_WAIT holds it, rsp_data = selected rdata sampled at end of READ_WAIT; then RESP.
REQ-022 RESP SHALL hold rsp_valid and rsp_data stable until rsp_ready; return to IDLE on transfer.
REQ-023 Accepted RUN: gpu_run high from next cycle while in RUNNING; 32-bit saturating cycle counter clears on entry and increments each RUNNING cycle.
REQ-024 RUNNING exits when, after RUN_MASK_CYCLES cycles, gpu_halted or gpu_exception is high, or when abort is high (any cycle); gpu_run SHALL be low the cycle after exit.
REQ-025 Run status word: bit0 halted, bit1 exception, bit2 aborted, bit3 timeout, bits[31:4] cycle_count[27:0] saturated at all ones; delivered via RESP.
REQ-026 gpu_*_we SHALL never be high while gpu_run is high; addresses zero and write data zero outside WRITE/READ states.
REQ-027 Reserved ops SHALL be consumed and answer rsp_data 32'hdeadbeef.
REQ-028 abort outside RUNNING SHALL have no effect; simultaneous halted and abort reports both bits set.

Reset
REQ-029 On reset_n low: state IDLE, cmd_ready 0 until first edge after release, rsp_valid 0, rsp_data 0, gpu_run 0, all we 0, addresses 0, wdata 0, counter 0.
REQ-030 Reset mid-run or mid-response SHALL drop gpu_run and rsp_valid immediately, with no partial write pulse.

Configuration
REQ-031 With GPU_HOST_TIMEOUT_EN defined, RUNNING SHALL also exit when the cycle counter reaches TIMEOUT_CYCLES (package constant, 2**20), setting status bit3.
REQ-032 Without GPU_HOST_TIMEOUT_EN, no timeout logic exists and status bit3 reads 0.

Structure
REQ-033 Package gpu_host_pkg SHALL hold the cmd_op encoding, state enum, status bit positions, TIMEOUT_CYCLES and the reserved-op constant.
REQ-034 Single module; no sub-module required.

Verification
REQ-035 WRITE_INST addr 0x0010 data 0x00500093 -> one-cycle gpu_inst_we with those values; READ_INST 0x0010 -> rsp_data 0x00500093.
REQ-036 RUN, GPU model halts at cycle 10 -> gpu_run high 10 cycles, status bit0=1, count=10.
REQ-037 RUN with halted already high -> ignored for 2 cycles, exits on cycle 3, count=3.
REQ-038 RUN, abort at cycle 5 -> status 0x...54 (bit2 set, count 5); gpu_run low the next cycle.
REQ-039 READ_DATA with rsp_ready low 20 cycles -> rsp_data stable, cmd_ready low throughout.
REQ-040 TIMEOUT_EN, GPU never halts -> exit at 2**20 cycles, bit3=1; reset_n low mid-run -> gpu_run 0 asynchronously.
